// File: rtl/lfm_pkg.sv
// Shared types and constants for the LFM DDS sequencer and FTW ramp.
package lfm_pkg;

  localparam int N_PHASE_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHIRP = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

endpackage

// File: rtl/lfm_ftw_ramp.sv
// Modular FTW accumulator: load a value, step up/down by delta, or hold.
module lfm_ftw_ramp
  import lfm_pkg::*;
#(
  parameter int N_PHASE = N_PHASE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [N_PHASE-1:0] load_val,
  input  logic               step,
  input  logic               step_down,
  input  logic [N_PHASE-1:0] delta,
  output logic [N_PHASE-1:0] ftw
);

  // Wrap-around is intentional: the FTW is a phase increment modulo 2^N_PHASE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftw <= '0;
    end else if (load) begin
      ftw <= load_val;
    end else if (step) begin
      ftw <= step_down ? (ftw - delta) : (ftw + delta);
    end
  end

endmodule

// File: rtl/lfm_chirp_ctrl.sv
// Burst sequencer for the LFM DDS: config handshake, chirp/gap timing and per-cycle DDS control.
module lfm_chirp_ctrl
  import lfm_pkg::*;
#(
  parameter int N_PHASE = N_PHASE_DEF,
  parameter int CNT_W   = 32,
  parameter int NCH_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [N_PHASE-1:0] cfg_ftw_start,
  input  logic [N_PHASE-1:0] cfg_ftw_delta,
  input  logic [CNT_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_gap,
  input  logic [NCH_W-1:0]   cfg_count,
  input  logic [1:0]         cfg_mode,
  input  logic               start,
  input  logic               abort,
  output logic [N_PHASE-1:0] ftw_out,
  output logic               dds_en,
  output logic               phase_clr,
  output logic               chirp_sync,
  output logic [NCH_W-1:0]   chirp_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             state, state_nxt;
  logic [N_PHASE-1:0] sh_ftw_start, sh_ftw_delta;
  logic [CNT_W-1:0]   sh_len, sh_gap;
  logic [NCH_W-1:0]   sh_count;
  logic [1:0]         sh_mode;
  logic [CNT_W-1:0]   samp_cnt, samp_nxt, gap_cnt, gap_nxt;
  logic [NCH_W-1:0]   idx_nxt;
  logic               ramp_load, ramp_step, ramp_dn, next_chirp;
  logic [N_PHASE-1:0] ramp_val;
  logic               sync_nxt, clr_nxt, done_nxt, err_nxt;
  logic               cfg_bad, last_samp, last_chirp, down_ramp;

  assign cfg_bad    = (sh_len == '0) || (sh_count == '0) || (sh_mode == MODE_RSVD);
  assign last_samp  = (samp_cnt == sh_len - 1'b1);
  assign last_chirp = (chirp_idx == sh_count - 1'b1);
  // Triangle alternates direction: odd chirps descend from the held end value.
  assign down_ramp  = (sh_mode == MODE_DOWN) || ((sh_mode == MODE_TRI) && chirp_idx[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_ftw_start <= '0;
      sh_ftw_delta <= '0;
      sh_len       <= '0;
      sh_gap       <= '0;
      sh_count     <= '0;
      sh_mode      <= '0;
    end else if (cfg_valid && cfg_ready) begin
      sh_ftw_start <= cfg_ftw_start;
      sh_ftw_delta <= cfg_ftw_delta;
      sh_len       <= cfg_len;
      sh_gap       <= cfg_gap;
      sh_count     <= cfg_count;
      sh_mode      <= cfg_mode;
    end
  end

  always_comb begin
    state_nxt  = state;
    samp_nxt   = samp_cnt;
    gap_nxt    = gap_cnt;
    idx_nxt    = chirp_idx;
    ramp_load  = 1'b0;
    ramp_val   = '0;
    ramp_step  = 1'b0;
    ramp_dn    = 1'b0;
    sync_nxt   = 1'b0;
    clr_nxt    = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    next_chirp = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          if (cfg_bad) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = ST_CHIRP;
            samp_nxt  = '0;
            idx_nxt   = '0;
            ramp_load = 1'b1;
            ramp_val  = sh_ftw_start;
            sync_nxt  = 1'b1;
            clr_nxt   = 1'b1;
          end
        end
      end
      ST_CHIRP: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          ramp_load = 1'b1;
        end else if (!last_samp) begin
          samp_nxt  = samp_cnt + 1'b1;
          ramp_step = 1'b1;
          ramp_dn   = down_ramp;
        end else if (last_chirp) begin
          state_nxt = ST_DONE;
          ramp_load = 1'b1;
          done_nxt  = 1'b1;
        end else if (sh_gap != '0) begin
          state_nxt = ST_GAP;
          gap_nxt   = CNT_W'(1);
        end else begin
          next_chirp = 1'b1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          ramp_load = 1'b1;
        end else if (gap_cnt == sh_gap) begin
          next_chirp = 1'b1;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Odd triangle chirps keep the accumulator; all others reload the start FTW.
    if (next_chirp) begin
      state_nxt = ST_CHIRP;
      samp_nxt  = '0;
      idx_nxt   = chirp_idx + 1'b1;
      sync_nxt  = 1'b1;
      clr_nxt   = (sh_mode != MODE_TRI);
      ramp_load = !((sh_mode == MODE_TRI) && !chirp_idx[0]);
      ramp_val  = sh_ftw_start;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      samp_cnt   <= '0;
      gap_cnt    <= '0;
      chirp_idx  <= '0;
      cfg_ready  <= 1'b1;
      dds_en     <= 1'b0;
      phase_clr  <= 1'b0;
      chirp_sync <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      samp_cnt   <= samp_nxt;
      gap_cnt    <= gap_nxt;
      chirp_idx  <= idx_nxt;
      cfg_ready  <= (state_nxt == ST_IDLE);
      dds_en     <= (state_nxt == ST_CHIRP);
      phase_clr  <= clr_nxt;
      chirp_sync <= sync_nxt;
      busy       <= (state_nxt == ST_CHIRP) || (state_nxt == ST_GAP);
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

  lfm_ftw_ramp #(.N_PHASE(N_PHASE)) u_ramp (
    .clk       (clk),
    .rst       (rst),
    .load      (ramp_load),
    .load_val  (ramp_val),
    .step      (ramp_step),
    .step_down (ramp_dn),
    .delta     (sh_ftw_delta),
    .ftw       (ftw_out)
  );

endmodule

// File: tb/tb_lfm_chirp_ctrl.sv
// Bench for lfm_chirp_ctrl: directed scenarios plus random bursts against a trace model.
module tb_lfm_chirp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_ftw_start, cfg_ftw_delta, cfg_len, cfg_gap;
  logic [15:0] cfg_count;
  logic [1:0]  cfg_mode;
  logic        start, abort;
  logic [31:0] ftw_out;
  logic        dds_en, phase_clr, chirp_sync, busy, done, err;
  logic [15:0] chirp_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] e_ftw[$];
  logic [22:0] e_ctl[$];
  logic [22:0] ctl_obs;

  lfm_chirp_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ftw_start(cfg_ftw_start), .cfg_ftw_delta(cfg_ftw_delta),
    .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_count(cfg_count), .cfg_mode(cfg_mode),
    .start(start), .abort(abort), .ftw_out(ftw_out), .dds_en(dds_en),
    .phase_clr(phase_clr), .chirp_sync(chirp_sync), .chirp_idx(chirp_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // chirp_idx is only meaningful while a burst is running
  assign ctl_obs = {dds_en, phase_clr, chirp_sync, busy, done, err, cfg_ready,
                    busy ? chirp_idx : 16'd0};

  function automatic logic [22:0] mk(input bit en, clr, sync, bsy, dn, er, rdy, input logic [15:0] idx);
    return {en, clr, sync, bsy, dn, er, rdy, idx};
  endfunction

  localparam logic [22:0] CTL_IDLE = 23'h010000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [31:0] fs, fd, ln, gp, input logic [15:0] cnt, input logic [1:0] md);
    cfg_ftw_start = fs; cfg_ftw_delta = fd; cfg_len = ln; cfg_gap = gp;
    cfg_count = cnt; cfg_mode = md; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Expected per-cycle trace from the cycle after start through the return to IDLE.
  task automatic build(input logic [31:0] fs, fd, input int len, gap, cnt, input logic [1:0] md);
    logic [31:0] base, v;
    bit dn;
    e_ftw.delete();
    e_ctl.delete();
    v = fs;
    for (int c = 0; c < cnt; c++) begin
      if (md == 2'd2 && (c % 2) == 1) begin
        base = fs + 32'(len - 1) * fd;
        dn = 1'b1;
      end else begin
        base = fs;
        dn = (md == 2'd1);
      end
      for (int k = 0; k < len; k++) begin
        v = dn ? base - 32'(k) * fd : base + 32'(k) * fd;
        e_ftw.push_back(v);
        e_ctl.push_back(mk(1'b1, (k == 0) && (md != 2'd2 || c == 0), k == 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'(c)));
      end
      if (c < cnt - 1)
        for (int g = 0; g < gap; g++) begin
          e_ftw.push_back(v);
          e_ctl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'(c)));
        end
    end
    e_ftw.push_back(32'd0);
    e_ctl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    e_ftw.push_back(32'd0);
    e_ctl.push_back(CTL_IDLE);
  endtask

  task automatic run_expect(input string tag, input bit hold_start, input bit poke_cfg);
    int n;
    n = e_ftw.size();
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (!hold_start) start = 1'b0;
      check({tag, "_ftw"}, 64'(ftw_out), 64'(e_ftw[i]));
      check({tag, "_ctl"}, 64'(ctl_obs), 64'(e_ctl[i]));
      if (poke_cfg && i == 0) cfg_valid = 1'b1;
      if (i == n - 2) cfg_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_ftw_start = '0; cfg_ftw_delta = '0; cfg_len = '0; cfg_gap = '0;
    cfg_count = '0; cfg_mode = '0;
    tick();
    check("reset_ftw", 64'(ftw_out), 64'd0);
    check("reset_ctl", 64'(ctl_obs), 64'(CTL_IDLE));
    check("reset_idx", 64'(chirp_idx), 64'd0);
    rst = 1'b0;
    tick();

    load_cfg(32'd100, 32'd5, 32'd4, 32'd2, 16'd2, 2'd0);
    build(32'd100, 32'd5, 4, 2, 2, 2'd0);
    run_expect("up", 1'b0, 1'b0);

    load_cfg(32'd0, 32'd10, 32'd3, 32'd0, 16'd2, 2'd2);
    build(32'd0, 32'd10, 3, 0, 2, 2'd2);
    run_expect("tri", 1'b0, 1'b0);

    load_cfg(32'd2, 32'd3, 32'd2, 32'd0, 16'd1, 2'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wrap_s0", 64'(ftw_out), 64'd2);
    tick();
    check("wrap_s1", 64'(ftw_out), 64'hFFFF_FFFF);
    repeat (2) tick();
    check("wrap_end", 64'(ctl_obs), 64'(CTL_IDLE));

    load_cfg(32'd9, 32'd1, 32'd0, 32'd0, 16'd1, 2'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rej_len", 64'(ctl_obs), 64'(CTL_IDLE | mk(0, 0, 0, 0, 0, 1, 0, 0)));
    tick();
    check("rej_len_clr", 64'(ctl_obs), 64'(CTL_IDLE));
    load_cfg(32'd9, 32'd1, 32'd3, 32'd0, 16'd1, 2'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rej_mode", 64'(ctl_obs), 64'(CTL_IDLE | mk(0, 0, 0, 0, 0, 1, 0, 0)));
    load_cfg(32'd9, 32'd1, 32'd3, 32'd0, 16'd0, 2'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rej_cnt", 64'(ctl_obs), 64'(CTL_IDLE | mk(0, 0, 0, 0, 0, 1, 0, 0)));

    load_cfg(32'd1000, 32'd7, 32'd5, 32'd1, 16'd3, 2'd0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start", 64'(ctl_obs), 64'(CTL_IDLE));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_s0", 64'(ftw_out), 64'd1000);
    tick();
    check("abort_s1", 64'(ftw_out), 64'd1007);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ftw", 64'(ftw_out), 64'd0);
    check("abort_ctl", 64'(ctl_obs), 64'(CTL_IDLE));
    tick();
    check("abort_nodone", 64'(ctl_obs), 64'(CTL_IDLE));

    load_cfg(32'd500, 32'd2, 32'd3, 32'd0, 16'd1, 2'd0);
    build(32'd500, 32'd2, 3, 0, 1, 2'd0);
    cfg_ftw_start = 32'd77; cfg_ftw_delta = 32'd9; cfg_len = 32'd2; cfg_mode = 2'd1;
    run_expect("cfgbusy", 1'b0, 1'b1);
    run_expect("cfghold", 1'b0, 1'b0);

    load_cfg(32'd50, 32'd1, 32'd2, 32'd0, 16'd1, 2'd0);
    build(32'd50, 32'd1, 2, 0, 1, 2'd0);
    run_expect("hold", 1'b1, 1'b0);
    tick();
    start = 1'b0;
    check("hold_restart_ftw", 64'(ftw_out), 64'd50);
    check("hold_restart_ctl", 64'(ctl_obs), 64'(mk(1, 1, 1, 1, 0, 0, 0, 0)));
    repeat (3) tick();

    load_cfg(32'd7, 32'd1, 32'd2, 32'd3, 16'd2, 2'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("gap_state", 64'(ctl_obs), 64'(mk(0, 0, 0, 1, 0, 0, 0, 0)));
    rst = 1'b1;
    #1;
    check("rst_async_ftw", 64'(ftw_out), 64'd0);
    check("rst_async_ctl", 64'(ctl_obs), 64'(CTL_IDLE));
    check("rst_async_idx", 64'(chirp_idx), 64'd0);
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_shadow_lost", 64'(ctl_obs), 64'(CTL_IDLE | mk(0, 0, 0, 0, 0, 1, 0, 0)));

    for (int it = 0; it < 12; it++) begin
      logic [31:0] fs, fd;
      int ln, gp, cn;
      logic [1:0] md;
      fs = $urandom;
      fd = $urandom;
      ln = $urandom_range(1, 5);
      gp = $urandom_range(0, 3);
      cn = $urandom_range(1, 3);
      md = 2'($urandom_range(0, 2));
      load_cfg(fs, fd, 32'(ln), 32'(gp), 16'(cn), md);
      build(fs, fd, ln, gp, cn, md);
      run_expect("rand", 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfm_chirp_ctrl.md
Name: lfm_chirp_ctrl

Overview:
Sequencer for the LFM DDS datapath (phase accumulator, FTW ramp and sine LUT).
- Accepts a chirp configuration through a valid/ready handshake.
- On start, runs a burst of N linear-FM chirps separated by programmable gaps.
- Drives the DDS per cycle: instantaneous FTW, enable, phase clear, chirp sync.
- Sits between the register/config interface and the DDS core. It owns all chirp timing, so the DDS no longer derives FTW from compile-time constants.

Parameters:
- N_PHASE, 32, phase accumulator / FTW width.
- CNT_W, 32, width of chirp-length and gap counters.
- NCH_W, 16, width of the chirp-count field and chirp index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- cfg_valid  in  1  config word valid.
- cfg_ready  out  1  config accepted. High only in IDLE.
- cfg_ftw_start  in  N_PHASE  FTW of first sample of the burst.
- cfg_ftw_delta  in  N_PHASE  per-sample FTW increment magnitude.
- cfg_len  in  CNT_W  samples per chirp.
- cfg_gap  in  CNT_W  idle cycles between chirps.
- cfg_count  in  NCH_W  chirps per burst.
- cfg_mode  in  2  0 = up, 1 = down, 2 = triangle, 3 = reserved.
- start  in  1  start burst (level sampled each cycle).
- abort  in  1  stop immediately.
- ftw_out  out  N_PHASE  FTW to DDS phase accumulator.
- dds_en  out  1  DDS advance enable.
- phase_clr  out  1  one-cycle DDS phase accumulator clear.
- chirp_sync  out  1  one-cycle marker on sample 0 of each chirp.
- chirp_idx  out  NCH_W  0-based index of current chirp.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at normal burst completion.
- err  out  1  one-cycle pulse on rejected start.

Behaviour:
- All outputs are registered.
- Reset values: every output 0 except cfg_ready = 1. Shadow config registers = 0. State = IDLE.
- States: IDLE, CHIRP, GAP, DONE.
- Config capture: on cfg_valid && cfg_ready, all cfg_* fields are latched into shadow registers. In any other state cfg_valid is ignored and the shadows hold.
- Start validation, IDLE with start = 1:
  - If shadow len == 0, count == 0 or mode == 3: err pulses the next cycle and the block stays in IDLE.
  - Otherwise the block enters CHIRP the next cycle.
- Start latency: start sampled in cycle t. In cycle t+1: ftw_out = ftw_start, dds_en = 1, phase_clr = 1, chirp_sync = 1, busy = 1, chirp_idx = 0.
- CHIRP, sample k (0..len-1), ftw_out:
  - Up: ftw_start + k·delta.
  - Down: ftw_start − k·delta.
  - Arithmetic is modulo 2^N_PHASE. No saturation, wrap is legal.
  - The sample counter resets at each chirp start.
- End of chirp, after sample len-1:
  - If chirp_idx == count-1: go to DONE.
  - Else if gap > 0: go to GAP.
  - Else: start the next chirp directly, back-to-back with no dead cycle.
- GAP: dds_en = 0, ftw_out holds the last value. It lasts exactly gap cycles, then the next chirp starts.
- chirp_idx increments on each chirp_sync after the first.
- Start FTW of each subsequent chirp:
  - Up and down modes: reloads ftw_start.
  - Triangle: even-indexed chirps ramp up from ftw_start. Odd-indexed chirps ramp down starting from the last FTW of the preceding chirp (ftw_start + (len-1)·delta). No multiplier is used: the held accumulator value is the start point.
- phase_clr pulses on the first sample of every chirp in up and down modes. In triangle mode it pulses only on chirp 0, for phase continuity.
- DONE: one cycle. done = 1, dds_en = 0, busy = 0, ftw_out = 0. Returns to IDLE the next cycle with cfg_ready = 1.
- Abort, sampled in CHIRP, GAP or DONE: the next cycle is IDLE with dds_en = 0, ftw_out = 0, busy = 0, and no done pulse.
- Simultaneous events:
  - abort and start together in IDLE: abort wins and nothing starts.
  - start while busy: ignored.
- Holding start high: a new burst begins the cycle after DONE's return to IDLE, i.e. a one-cycle IDLE gap.
- Reset asserted mid-burst forces reset values immediately (asynchronous). The shadow config is lost and must be reloaded.

Decomposition:
- Shared package lfm_pkg:
  - State enum.
  - Mode constants MODE_UP / MODE_DOWN / MODE_TRI / MODE_RSVD.
  - Default N_PHASE.
- One sub-module, lfm_ftw_ramp:
  - Ports: load (value), step (add or sub by delta), hold.
  - N_PHASE-wide modular accumulator.
  - Reused by the DDS core.
- The FSM, counters and handshake stay in lfm_chirp_ctrl.

Test Plan:
1. Basic up burst, sequence:
   - Stimulus: load start = 100, delta = 5, len = 4, gap = 2, count = 2, mode = 0; pulse start at t.
   - CHIRP samples: ftw_out = 100, 105, 110, 115 at t+1..t+4, then GAP for 2 cycles (dds_en = 0).
   - Second chirp: ftw_out = 100..115 at t+7..t+10.
   - Completion: done at t+11.
2. Basic up burst, sync signals: same stimulus as scenario 1 -> chirp_sync and phase_clr at t+1 and t+7; chirp_idx = 1 from t+7; busy high t+1..t+10.
3. Triangle, len = 3, delta = 10, start = 0, count = 2, gap = 0 -> ftw_out = 0, 10, 20, 20, 10, 0 contiguous; phase_clr only on the first sample; done after the 6th sample.
4. Wrap, mode = 1, start = 2, delta = 3, len = 2 -> ftw_out = 2, then 0xFFFFFFFF.
5. Rejected start: start with len = 0 -> err pulse one cycle later, busy stays 0. Separately, mode = 3 -> err.
6. Abort mid-chirp, handshake and reset:
   - Abort on chirp sample 1 -> next cycle dds_en = 0, ftw_out = 0, IDLE, no done.
   - cfg_valid during CHIRP -> not accepted (cfg_ready = 0).
   - rst mid-GAP -> all outputs at reset values immediately.
